// File: rtl/linebuf_bank_sched_pkg.sv
// Shared constants, FSM encoding and bank-to-base mapping for the upsampling line RAM.
// Used by the scheduler and by the PAL writer / HD reader blocks.
package linebuf_pkg;

    localparam int NUM_BANKS   = 4;
    localparam int BANK_DEPTH  = 2048;
    localparam int ADDR_W      = 13;
    localparam int PRIME_LINES = 1;
    localparam int BANK_W      = $clog2(NUM_BANKS);
    localparam int OFFS_W      = $clog2(BANK_DEPTH);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } sched_state_e;

    // Banks are contiguous, so the base is the bank index in the top address bits.
    function automatic logic [ADDR_W-1:0] bank_base(input logic [BANK_W-1:0] bank);
        return {bank, {OFFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/linebuf_bank_sched_if.sv
// Event pulses in, RAM bases and status out, for the line-buffer bank scheduler.
// Debug counters exist only when LINEBUF_SCHED_STATS_EN is defined.
interface linebuf_bank_sched_if;
    import linebuf_pkg::*;

    logic              i_wr_commit;
    logic              i_rd_line_start;
    logic              i_frame_start;
    logic [ADDR_W-1:0] o_wr_base;
    logic [ADDR_W-1:0] o_rd_base;
    logic              o_rd_blank;
    logic              o_repeat;
    logic              o_drop;
    logic [BANK_W-1:0] o_pending;
`ifdef LINEBUF_SCHED_STATS_EN
    logic [15:0]       o_repeat_cnt;
    logic [15:0]       o_drop_cnt;

    modport slave (
        input  i_wr_commit, i_rd_line_start, i_frame_start,
        output o_wr_base, o_rd_base, o_rd_blank, o_repeat, o_drop, o_pending,
        output o_repeat_cnt, o_drop_cnt
    );
    modport master (
        output i_wr_commit, i_rd_line_start, i_frame_start,
        input  o_wr_base, o_rd_base, o_rd_blank, o_repeat, o_drop, o_pending,
        input  o_repeat_cnt, o_drop_cnt
    );
`else
    modport slave (
        input  i_wr_commit, i_rd_line_start, i_frame_start,
        output o_wr_base, o_rd_base, o_rd_blank, o_repeat, o_drop, o_pending
    );
    modport master (
        output i_wr_commit, i_rd_line_start, i_frame_start,
        input  o_wr_base, o_rd_base, o_rd_blank, o_repeat, o_drop, o_pending
    );
`endif
endinterface

// File: rtl/linebuf_bank_sched_sat_cnt.sv
// 16-bit event counter that sticks at all-ones; synchronous clear beats increment.
module linebuf_sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    // Counter register with saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'h0000;
        end else if (clr) begin
            cnt <= 16'h0000;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'h0001;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/linebuf_bank_sched.sv
// Bank scheduler for the 4-bank PAL->HD line RAM: repeats or drops lines on rate mismatch.
// Optional repeat/drop counters under LINEBUF_SCHED_STATS_EN.
module linebuf_bank_sched
    import linebuf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    linebuf_bank_sched_if.slave  bus
);

    localparam logic [BANK_W-1:0] ONE_S       = BANK_W'(1);
    localparam logic [BANK_W-1:0] MAX_PEND_S  = BANK_W'(NUM_BANKS - 2);
    localparam logic [BANK_W-1:0] PRIME_LIM_S = BANK_W'(PRIME_LINES);

    sched_state_e      state_r,   state_s;
    logic [BANK_W-1:0] rd_ptr_r,  rd_ptr_s;
    logic [BANK_W-1:0] wr_ptr_r,  wr_ptr_s;
    logic [BANK_W-1:0] pending_r, pending_s;
    logic              repeat_s,  drop_s;
    logic [ADDR_W-1:0] wr_base_r, rd_base_r;
    logic              blank_r,   repeat_r, drop_r;

    // Next-state: frame start overrides; read decision precedes commit decision
    always_comb begin
        state_s   = state_r;
        rd_ptr_s  = rd_ptr_r;
        wr_ptr_s  = wr_ptr_r;
        pending_s = pending_r;
        repeat_s  = 1'b0;
        drop_s    = 1'b0;
        if (bus.i_frame_start) begin
            wr_ptr_s  = rd_ptr_r + ONE_S;
            pending_s = '0;
            state_s   = ST_PRIME;
        end else begin
            if (bus.i_rd_line_start && (state_r == ST_RUN)) begin
                if (pending_r != '0) begin
                    rd_ptr_s  = rd_ptr_r + ONE_S;
                    pending_s = pending_r - ONE_S;
                end else begin
                    repeat_s  = 1'b1;
                end
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            // Commit sees the post-read pending so a full ring plus a read never drops
            if (bus.i_wr_commit) begin
                if (pending_s < MAX_PEND_S) begin
                    wr_ptr_s  = wr_ptr_r + ONE_S;
                    pending_s = pending_s + ONE_S;
                end else begin
                    drop_s    = 1'b1;
                end
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            case (state_r)
                ST_PRIME: begin
                    if (pending_s >= PRIME_LIM_S) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PRIME;
                    end
                end
                ST_RUN:   state_s = ST_RUN;
                default:  state_s = ST_PRIME;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_PRIME;
            rd_ptr_r  <= '0;
            wr_ptr_r  <= ONE_S;
            pending_r <= '0;
            rd_base_r <= '0;
            wr_base_r <= bank_base(ONE_S);
            blank_r   <= 1'b1;
            repeat_r  <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            rd_ptr_r  <= rd_ptr_s;
            wr_ptr_r  <= wr_ptr_s;
            pending_r <= pending_s;
            rd_base_r <= bank_base(rd_ptr_s);
            wr_base_r <= bank_base(wr_ptr_s);
            blank_r   <= (state_s == ST_PRIME);
            repeat_r  <= repeat_s;
            drop_r    <= drop_s;
        end
    end

    assign bus.o_wr_base  = wr_base_r;
    assign bus.o_rd_base  = rd_base_r;
    assign bus.o_rd_blank = blank_r;
    assign bus.o_repeat   = repeat_r;
    assign bus.o_drop     = drop_r;
    assign bus.o_pending  = pending_r;

`ifdef LINEBUF_SCHED_STATS_EN
    // Counters step on the same edge as the pulses they count
    linebuf_sat_cnt u_repeat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.i_frame_start),
        .inc   (repeat_s),
        .cnt   (bus.o_repeat_cnt)
    );

    linebuf_sat_cnt u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.i_frame_start),
        .inc   (drop_s),
        .cnt   (bus.o_drop_cnt)
    );
`endif

endmodule

// File: tb/tb_linebuf_bank_sched.sv
// Directed, table-driven bench for linebuf_bank_sched; counter checks under LINEBUF_SCHED_STATS_EN.
module tb_linebuf_bank_sched;
    import linebuf_pkg::*;

    typedef struct {
        logic              c;
        logic              r;
        logic              f;
        logic [ADDR_W-1:0] wb;
        logic [ADDR_W-1:0] rb;
        logic              blank;
        logic              rep;
        logic              drop;
        logic [BANK_W-1:0] pend;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vq[$];

    linebuf_bank_sched_if bus ();

    linebuf_bank_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " wr_base"},  int'(bus.o_wr_base),  int'(v.wb));
        check({tag, " rd_base"},  int'(bus.o_rd_base),  int'(v.rb));
        check({tag, " rd_blank"}, int'(bus.o_rd_blank), int'(v.blank));
        check({tag, " repeat"},   int'(bus.o_repeat),   int'(v.rep));
        check({tag, " drop"},     int'(bus.o_drop),     int'(v.drop));
        check({tag, " pending"},  int'(bus.o_pending),  int'(v.pend));
    endtask

    task automatic drive(input logic c, input logic r, input logic f);
        bus.i_wr_commit     = c;
        bus.i_rd_line_start = r;
        bus.i_frame_start   = f;
    endtask

    task automatic add(input logic c, input logic r, input logic f,
                       input int wb, input int rb, input logic bl,
                       input logic rp, input logic dr, input int pd);
        vec_t v;
        v.c = c; v.r = r; v.f = f;
        v.wb = ADDR_W'(wb); v.rb = ADDR_W'(rb);
        v.blank = bl; v.rep = rp; v.drop = dr; v.pend = BANK_W'(pd);
        vq.push_back(v);
    endtask

    initial begin
        vec_t rv;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        //   c     r     f     wr    rd    blank rep   drop  pend
        add(1'b1, 1'b0, 1'b0, 4096,    0, 1'b0, 1'b0, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 4096, 2048, 1'b0, 1'b0, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 4096, 2048, 1'b0, 1'b1, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 4096, 2048, 1'b0, 1'b1, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 4096, 2048, 1'b0, 1'b1, 1'b0, 0);
        add(1'b0, 1'b0, 1'b0, 4096, 2048, 1'b0, 1'b0, 1'b0, 0);
        add(1'b0, 1'b0, 1'b1, 4096, 2048, 1'b1, 1'b0, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 4096, 2048, 1'b1, 1'b0, 1'b0, 0);
        add(1'b1, 1'b0, 1'b0, 6144, 2048, 1'b0, 1'b0, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0,    0, 2048, 1'b0, 1'b0, 1'b0, 2);
        add(1'b1, 1'b0, 1'b0,    0, 2048, 1'b0, 1'b0, 1'b1, 2);
        add(1'b1, 1'b0, 1'b0,    0, 2048, 1'b0, 1'b0, 1'b1, 2);
        add(1'b1, 1'b1, 1'b0, 2048, 4096, 1'b0, 1'b0, 1'b0, 2);
        add(1'b0, 1'b1, 1'b0, 2048, 6144, 1'b0, 1'b0, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 2048,    0, 1'b0, 1'b0, 1'b0, 0);
        add(1'b1, 1'b1, 1'b0, 4096,    0, 1'b0, 1'b1, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 4096, 2048, 1'b0, 1'b0, 1'b0, 0);
        add(1'b1, 1'b0, 1'b0, 6144, 2048, 1'b0, 1'b0, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 6144, 4096, 1'b0, 1'b0, 1'b0, 0);
        add(1'b1, 1'b0, 1'b0,    0, 4096, 1'b0, 1'b0, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0,    0, 6144, 1'b0, 1'b0, 1'b0, 0);
        add(1'b1, 1'b0, 1'b1,    0, 6144, 1'b1, 1'b0, 1'b0, 0);
        add(1'b1, 1'b1, 1'b1,    0, 6144, 1'b1, 1'b0, 1'b0, 0);
        add(1'b1, 1'b0, 1'b0, 2048, 6144, 1'b0, 1'b0, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 2048,    0, 1'b0, 1'b0, 1'b0, 0);

        rv.c = 1'b0; rv.r = 1'b0; rv.f = 1'b0;
        rv.wb = ADDR_W'(2048); rv.rb = ADDR_W'(0);
        rv.blank = 1'b1; rv.rep = 1'b0; rv.drop = 1'b0; rv.pend = BANK_W'(0);

        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset", rv);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_reset", rv);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].c, vq[i].r, vq[i].f);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vq[i]);
        end
        drive(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run, sampled between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", rv);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0);
        check("post_rst_commit wr_base", int'(bus.o_wr_base), 4096);
        check("post_rst_commit pending", int'(bus.o_pending), 1);
        check("post_rst_commit blank",   int'(bus.o_rd_blank), 0);

`ifdef LINEBUF_SCHED_STATS_EN
        drive(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("stats drop_cnt", int'(bus.o_drop_cnt), 1);
        drive(1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("stats repeat_cnt_zero", int'(bus.o_repeat_cnt), 0);
        repeat (70000) @(posedge clk);
        #1;
        check("stats repeat_cnt_sat", int'(bus.o_repeat_cnt), 65535);
        check("stats drop_cnt_hold", int'(bus.o_drop_cnt), 1);
        drive(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0);
        check("stats repeat_cnt_clr", int'(bus.o_repeat_cnt), 0);
        check("stats drop_cnt_clr", int'(bus.o_drop_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/linebuf_bank_sched.md
Name: linebuf_bank_sched

Overview:
- Schedules the 4-bank upsampling line RAM shared between the PAL line writer and the HD line reader.
- Decides which bank the writer fills and which bank the reader displays.
- Repeats the displayed line when the HD side outruns PAL and drops the incoming line when PAL outruns HD.
- Issues RAM base addresses to both sides; re-primes on every PAL frame start.

Parameters:
- NUM_BANKS, 4, line banks in the RAM; power of two, >=3.
- BANK_DEPTH, 2048, words per bank; power of two.
- ADDR_W, 13, RAM address width; must equal log2(NUM_BANKS*BANK_DEPTH).
- PRIME_LINES, 1, committed lines required before the first read advance after a frame start; range 1..NUM_BANKS-2.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_wr_commit  in  1  one-cycle pulse: writer finished the current line (PAL hsync edge).
- i_rd_line_start  in  1  one-cycle pulse: reader begins a new HD line.
- i_frame_start  in  1  one-cycle pulse: PAL vsync edge.
- o_wr_base  out  ADDR_W  base address of the bank being written.
- o_rd_base  out  ADDR_W  base address of the bank being read.
- o_rd_blank  out  1  reader outputs black (PRIME state).
- o_repeat  out  1  pulse: read line start kept the same bank.
- o_drop  out  1  pulse: commit discarded; the writer overwrites the same bank.
- o_pending  out  log2(NUM_BANKS)  committed lines not yet displayed.

Behaviour:
- State: rd_ptr (bank being displayed), wr_ptr (bank being written), pending (0..NUM_BANKS-2). Pointers wrap modulo NUM_BANKS.
- Invariant: wr_ptr == rd_ptr+pending+1 mod NUM_BANKS.
- Reset values: rd_ptr=0, wr_ptr=1, pending=0, state PRIME.
- Output reset values: o_rd_base=0, o_wr_base=BANK_DEPTH, o_rd_blank=1, o_repeat=0, o_drop=0, o_pending=0.
- All outputs are registered. Bases are bank*BANK_DEPTH. Every output reflects an event one cycle after the input pulse.
- FSM state PRIME:
  - i_rd_line_start: no pointer change, no o_repeat.
  - i_wr_commit: pending<NUM_BANKS-2 -> wr_ptr+1, pending+1; otherwise o_drop.
  - Transition to RUN in the same cycle that pending reaches >= PRIME_LINES; o_rd_blank deasserts with it.
- FSM state RUN, i_rd_line_start:
  - pending>0 -> rd_ptr+1, pending-1.
  - pending==0 -> o_repeat pulse, rd_ptr unchanged.
- FSM state RUN, i_wr_commit: same rule as in PRIME.
- Simultaneous read start and commit in one cycle:
  - The read decision uses the pre-commit pending; the line committed this cycle cannot be displayed until the next read start.
  - The commit decision uses the post-read pending. A full ring with a simultaneous read therefore advances both pointers, pending is unchanged, and there is no drop.
- i_frame_start (any state) has the highest priority:
  - wr_ptr=rd_ptr+1, pending=0, state PRIME, o_rd_blank=1.
  - A same-cycle commit or read start is ignored; no o_repeat or o_drop.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); outputs are valid from the first clk edge after rst_n rises.
- Pulses on o_repeat and o_drop are exactly one cycle wide, even for back-to-back events.

Optional Feature:
- Macro LINEBUF_SCHED_STATS_EN.
- Defined:
  - Adds outputs o_repeat_cnt[15:0] and o_drop_cnt[15:0].
  - Each counter saturates at 16'hFFFF and counts its pulse.
  - Both counters clear on rst_n and on i_frame_start. They are readable for debug/UI overlay.
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package linebuf_pkg holds NUM_BANKS, BANK_DEPTH, ADDR_W, the derived BANK_W=log2(NUM_BANKS), the state encoding (PRIME=0, RUN=1) and the bank-to-base function.
- Shared with the writer and reader blocks.
- One sub-module: linebuf_sat_cnt (16-bit saturating, clear input), instantiated twice under the macro.

Test Plan:
- Reset, then 1 commit -> o_wr_base 2048->4096, o_pending=1, o_rd_blank falls one cycle after the commit; the next read start gives o_rd_base=2048, o_pending=0.
- RUN with pending=0, 3 read starts and no commits -> three o_repeat pulses, o_rd_base constant, o_pending stays 0.
- 3 commits with no reads from a fresh frame -> pending=2 after two; the third gives o_drop, o_wr_base unchanged, pending=2.
- pending=2 plus a simultaneous commit and read start -> no o_drop, no o_repeat, both bases advance one bank, pending=2; with the pending=0 variant -> o_repeat and pending=1.
- rd_ptr=3, read advance -> o_rd_base wraps 6144->0; i_frame_start coincident with commit -> commit ignored, pending=0, o_rd_blank=1, o_wr_base=(rd_ptr+1)*2048.
- With LINEBUF_SCHED_STATS_EN: force 70000 repeats -> o_repeat_cnt=65535; i_frame_start -> both counters 0.
